// File: rtl/stopwatch_pkg.sv
// Shared types and default parameters for the stopwatch control slice.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUNNING  = 2'd1,
        LAP_SHOW = 2'd2,
        PAUSED   = 2'd3
    } sw_state_t;

    localparam int HOLD_CYCLES_DEFAULT = 50_000_000;
    localparam int LAP_CNT_W_DEFAULT   = 4;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a clk-synchronous button level.
// A level already high when reset releases is not an edge until it has been seen low.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic level_q;
    logic armed;

    // History flop plus an arm flag that is set once the level has been observed low.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= 1'b0;
            armed   <= 1'b0;
        end else begin
            level_q <= level;
            armed   <= armed | ~level;
        end
    end

    assign rise = level & ~level_q & armed;

endmodule

// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch control FSM: button edges to counter run/clear, lap capture and lap display hold.
module stopwatch_lap_ctrl
    import stopwatch_pkg::*;
#(
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT,
    parameter int LAP_CNT_W   = LAP_CNT_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ss_btn,
    input  logic                 lr_btn,
    output logic                 count_en,
    output logic                 count_clr,
    output logic                 lap_en,
    output logic                 lap_clr,
    output logic                 show_lap,
    output logic [LAP_CNT_W-1:0] lap_num
);

    localparam int TIMER_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [TIMER_W-1:0]   TIMER_LOAD = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [LAP_CNT_W-1:0] LAP_MAX    = {LAP_CNT_W{1'b1}};

    sw_state_t            state;
    logic [TIMER_W-1:0]   timer;
    logic [LAP_CNT_W-1:0] lap_inc;
    logic                 ss_rise;
    logic                 lr_rise;

    rise_detect u_ss_rise (
        .clk   (clk),
        .rst   (rst),
        .level (ss_btn),
        .rise  (ss_rise)
    );

    rise_detect u_lr_rise (
        .clk   (clk),
        .rst   (rst),
        .level (lr_btn),
        .rise  (lr_rise)
    );

    // Saturating lap counter increment.
    always_comb begin
        lap_inc = lap_num;
        if (lap_num == LAP_MAX) begin
            lap_inc = LAP_MAX;
        end else begin
            lap_inc = lap_num + LAP_CNT_W'(1);
        end
    end

    // State register, hold timer and registered outputs; ss edges take priority over lr edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            count_en  <= 1'b0;
            count_clr <= 1'b0;
            lap_en    <= 1'b0;
            lap_clr   <= 1'b0;
            show_lap  <= 1'b0;
            lap_num   <= '0;
        end else begin
            count_clr <= 1'b0;
            lap_en    <= 1'b0;
            lap_clr   <= 1'b0;
            case (state)
                IDLE: begin
                    if (ss_rise) begin
                        state    <= RUNNING;
                        count_en <= 1'b1;
                    end
                end
                RUNNING: begin
                    if (ss_rise) begin
                        state    <= PAUSED;
                        count_en <= 1'b0;
                    end else if (lr_rise) begin
                        state    <= LAP_SHOW;
                        timer    <= TIMER_LOAD;
                        lap_en   <= 1'b1;
                        show_lap <= 1'b1;
                        lap_num  <= lap_inc;
                    end
                end
                LAP_SHOW: begin
                    if (ss_rise) begin
                        state    <= PAUSED;
                        timer    <= '0;
                        count_en <= 1'b0;
                        show_lap <= 1'b0;
                    end else if (lr_rise) begin
                        // A new lap wins over an expiring timer and restarts the hold.
                        timer    <= TIMER_LOAD;
                        lap_en   <= 1'b1;
                        lap_num  <= lap_inc;
                    end else if (timer == '0) begin
                        state    <= RUNNING;
                        show_lap <= 1'b0;
                    end else begin
                        timer    <= timer - TIMER_W'(1);
                    end
                end
                PAUSED: begin
                    if (ss_rise) begin
                        state    <= RUNNING;
                        count_en <= 1'b1;
                    end else if (lr_rise) begin
                        state     <= IDLE;
                        count_clr <= 1'b1;
                        lap_clr   <= 1'b1;
                        lap_num   <= '0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    timer    <= '0;
                    count_en <= 1'b0;
                    show_lap <= 1'b0;
                    lap_num  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Table-driven bench for stopwatch_lap_ctrl (HOLD_CYCLES=4, LAP_CNT_W=2) with an output scoreboard.
module tb_stopwatch_lap_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ss_btn = 1'b0;
    logic       lr_btn = 1'b0;
    logic       count_en, count_clr, lap_en, lap_clr, show_lap;
    logic [1:0] lap_num;

    stopwatch_lap_ctrl #(.HOLD_CYCLES(4), .LAP_CNT_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .ss_btn    (ss_btn),
        .lr_btn    (lr_btn),
        .count_en  (count_en),
        .count_clr (count_clr),
        .lap_en    (lap_en),
        .lap_clr   (lap_clr),
        .show_lap  (show_lap),
        .lap_num   (lap_num)
    );

    always #5 clk = ~clk;

    // Expected word layout: {count_en, count_clr, lap_en, lap_clr, show_lap, lap_num[1:0]}
    typedef struct {
        logic       rst;
        logic       ss;
        logic       lr;
        logic [6:0] exp;
    } vec_t;

    vec_t       vecs[$];
    logic [6:0] exp_q[$];
    int         id_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    bit         draining = 1'b0;

    task automatic add(input logic r, input logic s, input logic l,
                       input logic ce, input logic cc, input logic le,
                       input logic lc, input logic sh, input logic [1:0] n);
        vec_t v;
        v.rst = r;
        v.ss  = s;
        v.lr  = l;
        v.exp = {ce, cc, le, lc, sh, n};
        vecs.push_back(v);
    endtask

    // Monitor: compares DUT outputs after each edge against the oldest pending expectation.
    always @(posedge clk) begin
        logic [6:0] act;
        logic [6:0] exp;
        int         id;
        #1;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            id  = id_q.pop_front();
            act = {count_en, count_clr, lap_en, lap_clr, show_lap, lap_num};
            n_tests++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL vec%0d: got {ce,cc,le,lc,sh,num}=%b_%b_%b_%b_%b_%0d expected %b_%b_%b_%b_%b_%0d",
                         id, act[6], act[5], act[4], act[3], act[2], act[1:0],
                         exp[6], exp[5], exp[4], exp[3], exp[2], exp[1:0]);
            end
        end
    end

    initial begin
        // Reset state
        add(1,0,0, 0,0,0,0,0,2'd0);
        add(1,0,0, 0,0,0,0,0,2'd0);
        add(0,0,0, 0,0,0,0,0,2'd0);
        // Start, then ss held high for 10 cycles does nothing further
        add(0,1,0, 1,0,0,0,0,2'd0);
        for (int i = 0; i < 10; i++) add(0,1,0, 1,0,0,0,0,2'd0);
        add(0,0,0, 1,0,0,0,0,2'd0);
        // First lap: lap_en one cycle, show_lap four cycles
        add(0,0,1, 1,0,1,0,1,2'd1);
        add(0,0,0, 1,0,0,0,1,2'd1);
        add(0,0,0, 1,0,0,0,1,2'd1);
        add(0,0,0, 1,0,0,0,1,2'd1);
        add(0,0,0, 1,0,0,0,0,2'd1);
        // Second lap, third lap exactly at timer expiry, fourth lap saturates
        add(0,0,1, 1,0,1,0,1,2'd2);
        add(0,0,0, 1,0,0,0,1,2'd2);
        add(0,0,0, 1,0,0,0,1,2'd2);
        add(0,0,0, 1,0,0,0,1,2'd2);
        add(0,0,1, 1,0,1,0,1,2'd3);
        add(0,0,0, 1,0,0,0,1,2'd3);
        add(0,0,1, 1,0,1,0,1,2'd3);
        add(0,0,0, 1,0,0,0,1,2'd3);
        add(0,0,0, 1,0,0,0,1,2'd3);
        add(0,0,0, 1,0,0,0,1,2'd3);
        add(0,0,0, 1,0,0,0,0,2'd3);
        // Pause, then clear back to IDLE
        add(0,1,0, 0,0,0,0,0,2'd3);
        add(0,0,0, 0,0,0,0,0,2'd3);
        add(0,0,1, 0,1,0,1,0,2'd0);
        add(0,0,0, 0,0,0,0,0,2'd0);
        // lr in IDLE is ignored
        add(0,0,1, 0,0,0,0,0,2'd0);
        add(0,0,0, 0,0,0,0,0,2'd0);
        // Run, take one lap, let it expire
        add(0,1,0, 1,0,0,0,0,2'd0);
        add(0,0,0, 1,0,0,0,0,2'd0);
        add(0,0,1, 1,0,1,0,1,2'd1);
        add(0,0,0, 1,0,0,0,1,2'd1);
        add(0,0,0, 1,0,0,0,1,2'd1);
        add(0,0,0, 1,0,0,0,1,2'd1);
        add(0,0,0, 1,0,0,0,0,2'd1);
        // Simultaneous ss and lr while RUNNING: pause, no lap
        add(0,1,1, 0,0,0,0,0,2'd1);
        add(0,0,0, 0,0,0,0,0,2'd1);
        add(0,1,0, 1,0,0,0,0,2'd1);
        add(0,0,0, 1,0,0,0,0,2'd1);
        // ss during LAP_SHOW pauses and drops the lap display
        add(0,0,1, 1,0,1,0,1,2'd2);
        add(0,1,0, 0,0,0,0,0,2'd2);
        add(0,0,0, 0,0,0,0,0,2'd2);
        add(0,1,0, 1,0,0,0,0,2'd2);
        add(0,0,0, 1,0,0,0,0,2'd2);
        // Reset during LAP_SHOW, then lr in IDLE does nothing
        add(0,0,1, 1,0,1,0,1,2'd3);
        add(0,0,0, 1,0,0,0,1,2'd3);
        add(1,0,0, 0,0,0,0,0,2'd0);
        add(0,0,0, 0,0,0,0,0,2'd0);
        add(0,0,1, 0,0,0,0,0,2'd0);
        add(0,0,0, 0,0,0,0,0,2'd0);
        // ss held high across reset release: no edge until seen low
        add(1,1,0, 0,0,0,0,0,2'd0);
        add(0,1,0, 0,0,0,0,0,2'd0);
        add(0,1,0, 0,0,0,0,0,2'd0);
        add(0,0,0, 0,0,0,0,0,2'd0);
        add(0,1,0, 1,0,0,0,0,2'd0);
        add(0,0,0, 1,0,0,0,0,2'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst    = vecs[i].rst;
            ss_btn = vecs[i].ss;
            lr_btn = vecs[i].lr;
            exp_q.push_back(vecs[i].exp);
            id_q.push_back(i);
        end
        @(negedge clk);
        draining = 1'b1;
        @(posedge clk);
        #3;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
